// File: rtl/debug_trace_reader.sv
// Debug trace capture buffer: records a window of debug words around a masked-compare
// trigger into block RAM and streams it out as 16-bit words over a valid/ready port.
module debug_trace_reader #(
  parameter int unsigned WIDTH      = 53,
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned PRETRIG    = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] debug_i,
  input  logic [WIDTH-1:0] trig_mask_i,
  input  logic [WIDTH-1:0] trig_value_i,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output logic [15:0]      rd_data_o,
  output logic             rd_last_o,
  output logic [2:0]       state_o,
  output logic             triggered_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  localparam logic [AW-1:0] FILL_LAST = AW'(PRETRIG - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRETRIG - 2);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);
  localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_ARMED   = 3'd2,
    ST_POST    = 3'd3,
    ST_READOUT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, cnt_q, trig_ptr_q;
  logic            wr_en, arm_go, trig_go, trig_hit;

  logic [WIDTH-1:0] mem [DEPTH];

  logic            in_ro, rd_issue, q_take, out_adv;
  logic [CW-1:0]   rd_cnt_q;
  logic [AW-1:0]   rd_addr;
  logic [WIDTH-1:0] q_data_q, samp_q, src_data;
  logic            q_vld_q, q_last_q, samp_vld_q, samp_last_q;
  logic [1:0]      wsel_q, src_w;
  logic            src_vld, src_last;
  logic [63:0]     src_ext;
  logic [15:0]     src_word;

  assign trig_hit = ((debug_i ^ trig_value_i) & trig_mask_i) == '0;
  assign state_o  = state_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and capture strobes; abort overrides every other event
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    arm_go  = 1'b0;
    trig_go = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arm_i) begin
          state_d = ST_FILL;
          arm_go  = 1'b1;
        end
      end
      ST_FILL: begin
        wr_en = 1'b1;
        if (cnt_q == FILL_LAST) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        wr_en = 1'b1;
        if (trig_hit) begin
          state_d = ST_POST;
          trig_go = 1'b1;
        end
      end
      ST_POST: begin
        wr_en = 1'b1;
        if (cnt_q == POST_LAST) state_d = ST_READOUT;
      end
      ST_READOUT: begin
        if (rd_valid_o && rd_ready_i && rd_last_o) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d = ST_IDLE;
      arm_go  = 1'b0;
      trig_go = 1'b0;
    end
  end

  // Write pointer, phase counter and trigger bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      trig_ptr_q  <= '0;
      triggered_o <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        cnt_q    <= (state_d == state_q) ? cnt_q + AW'(1) : '0;
      end
      if (arm_go) begin
        wr_ptr_q    <= '0;
        cnt_q       <= '0;
        triggered_o <= 1'b0;
      end
      if (trig_go) begin
        trig_ptr_q  <= wr_ptr_q;
        triggered_o <= 1'b1;
      end
    end
  end

  // Readout source: the held sample if present, else the RAM output register
  assign in_ro    = (state_q == ST_READOUT) && !abort_i;
  assign rd_addr  = trig_ptr_q - PRE_OFS + rd_cnt_q[AW-1:0];
  assign src_vld  = samp_vld_q | q_vld_q;
  assign src_data = samp_vld_q ? samp_q : q_data_q;
  assign src_w    = samp_vld_q ? wsel_q : 2'd0;
  assign src_last = samp_vld_q ? samp_last_q : q_last_q;
  assign src_ext  = 64'(src_data);
  assign src_word = src_ext[{src_w, 4'b0000} +: 16];
  assign out_adv  = src_vld && (!rd_valid_o || rd_ready_i);
  assign q_take   = q_vld_q && out_adv && (!samp_vld_q || (wsel_q == 2'd3));
  assign rd_issue = in_ro && !rd_cnt_q[AW] && (!q_vld_q || q_take);

  // Sample RAM plus data-only pipeline registers
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= debug_i;
    if (rd_issue) begin
      q_data_q <= mem[rd_addr];
      q_last_q <= (rd_cnt_q == LAST_IDX);
    end
    if (q_take) begin
      samp_q      <= q_data_q;
      samp_last_q <= q_last_q;
    end
  end

  // Readout control and registered output port
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !in_ro) begin
      rd_valid_o <= 1'b0;
      rd_last_o  <= 1'b0;
      rd_cnt_q   <= '0;
      q_vld_q    <= 1'b0;
      samp_vld_q <= 1'b0;
      wsel_q     <= 2'd0;
      if (!rst_n_i) rd_data_o <= '0;
    end else begin
      if (rd_issue) begin
        rd_cnt_q <= rd_cnt_q + CW'(1);
        q_vld_q  <= 1'b1;
      end else if (q_take) begin
        q_vld_q <= 1'b0;
      end
      if (out_adv) begin
        rd_valid_o <= 1'b1;
        rd_data_o  <= src_word;
        rd_last_o  <= src_last && (src_w == 2'd3);
        if (q_take) begin
          samp_vld_q <= 1'b1;
          wsel_q     <= samp_vld_q ? 2'd0 : 2'd1;
        end else if (wsel_q == 2'd3) begin
          samp_vld_q <= 1'b0;
          wsel_q     <= 2'd0;
        end else begin
          wsel_q <= wsel_q + 2'd1;
        end
      end else if (rd_ready_i) begin
        rd_valid_o <= 1'b0;
        rd_last_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_debug_trace_reader.sv
// Self-checking bench for debug_trace_reader: control-vector table, then captures
// checked against a window model built from the recorded debug history.
module tb_debug_trace_reader;

  localparam int W  = 53;
  localparam int DL = 4;
  localparam int PT = 4;
  localparam int D  = 16;
  localparam int NW = 4 * D;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [W-1:0]  debug_i, trig_mask_i, trig_value_i;
  logic          arm_i, abort_i, rd_ready_i;
  logic          rd_valid_o, rd_last_o, triggered_o;
  logic [15:0]   rd_data_o;
  logic [2:0]    state_o;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [W-1:0]  hist[$];
  logic [15:0]   rx_words[$];
  logic [15:0]   ref1[$];

  debug_trace_reader #(.WIDTH(W), .DEPTH_LOG2(DL), .PRETRIG(PT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .debug_i(debug_i),
    .trig_mask_i(trig_mask_i), .trig_value_i(trig_value_i),
    .arm_i(arm_i), .abort_i(abort_i), .rd_ready_i(rd_ready_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
    .state_o(state_o), .triggered_o(triggered_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Record the debug word sampled at the coming edge, then step past it
  task automatic tick();
    hist.push_back(debug_i);
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic hit(input logic [W-1:0] d, input logic [W-1:0] m, input logic [W-1:0] v);
    return ((d ^ v) & m) == '0;
  endfunction

  function automatic logic [W-1:0] gen_dbg(input int mode, input int base);
    logic [63:0] r;
    if (mode == 0) return W'(hist.size() - base);
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  // One capture: arm, feed debug words, drain readout; optionally interrupt after stop_after words
  task automatic run_capture(input string tag, input int mode, input logic [W-1:0] m,
                             input logic [W-1:0] v, input int stall_pct,
                             input int stop_after, input int stop_kind);
    int base, trig_e, e, got, budget, first_vld_e;
    logic [15:0] exp_w[$];
    logic [63:0] s;
    logic prev_stall, prev_last;
    logic [15:0] prev_data;
    bit done;
    trig_mask_i = m;
    trig_value_i = v;
    rx_words.delete();
    base = hist.size();
    trig_e = -1; got = 0; budget = 3000; first_vld_e = -1;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0; done = 1'b0;
    arm_i = 1'b1;
    rd_ready_i = 1'b1;
    debug_i = gen_dbg(mode, base);
    tick();
    arm_i = 1'b0;
    while (!done) begin
      if (budget == 0) begin
        chk({tag, " timeout"}, 64'(got), 64'(NW));
        break;
      end
      budget--;
      if (stop_after > 0 && got == stop_after) begin
        if (stop_kind == 1) rst_n_i = 1'b0;
        else abort_i = 1'b1;
        rd_ready_i = 1'b1;
        debug_i = gen_dbg(mode, base);
        tick();
        rst_n_i = 1'b1;
        abort_i = 1'b0;
        chk({tag, " stop state"}, 64'(state_o), 64'd0);
        chk({tag, " stop valid"}, 64'(rd_valid_o), 64'd0);
        chk({tag, " stop last"}, 64'(rd_last_o), 64'd0);
        if (stop_kind == 1) begin
          chk({tag, " reset data"}, 64'(rd_data_o), 64'd0);
          chk({tag, " reset trig"}, 64'(triggered_o), 64'd0);
        end else begin
          chk({tag, " abort trig"}, 64'(triggered_o), 64'd1);
        end
        break;
      end
      debug_i = gen_dbg(mode, base);
      rd_ready_i = (int'($urandom_range(99)) >= stall_pct);
      if (prev_stall) begin
        chk({tag, " stall valid"}, 64'(rd_valid_o), 64'd1);
        chk({tag, " stall data"}, 64'(rd_data_o), 64'(prev_data));
        chk({tag, " stall last"}, 64'(rd_last_o), 64'(prev_last));
      end
      if (rd_valid_o && first_vld_e < 0) begin
        first_vld_e = hist.size() - 1;
        chk({tag, " first valid edge"}, 64'(first_vld_e), 64'(trig_e + D - PT + 1));
      end
      if (rd_valid_o && rd_ready_i) begin
        if (got < exp_w.size()) chk({tag, " word"}, 64'(rd_data_o), 64'(exp_w[got]));
        else chk({tag, " word before window"}, 64'(got), 64'(exp_w.size()));
        chk({tag, " last"}, 64'(rd_last_o), 64'(got == NW - 1));
        rx_words.push_back(rd_data_o);
        got++;
      end
      prev_stall = rd_valid_o && !rd_ready_i;
      prev_data = rd_data_o;
      prev_last = rd_last_o;
      tick();
      e = hist.size() - 1;
      if (trig_e < 0 && e >= base + PT + 1 && hit(hist[e], m, v)) trig_e = e;
      if (trig_e >= 0 && e == trig_e + D - PT - 1) begin
        for (int k = 0; k < D; k++) begin
          s = 64'(hist[trig_e - PT + k]);
          for (int j = 0; j < 4; j++) exp_w.push_back(s[16*j +: 16]);
        end
      end
      if (got == NW) begin
        chk({tag, " end state"}, 64'(state_o), 64'd0);
        chk({tag, " end valid"}, 64'(rd_valid_o), 64'd0);
        chk({tag, " end trig"}, 64'(triggered_o), 64'd1);
        done = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic         rst_n;
    logic         arm;
    logic         abort;
    logic [W-1:0] dbg;
    logic [2:0]   st;
    logic         trig;
    logic         vld;
  } vec_t;

  initial begin
    vec_t tbl[13];
    logic [W-1:0] tv, m, v;
    logic [63:0] r;

    rst_n_i = 1'b0; debug_i = '0; trig_mask_i = '1; trig_value_i = '0;
    arm_i = 1'b0; abort_i = 1'b0; rd_ready_i = 1'b1;
    tick(); tick();
    rst_n_i = 1'b1;

    // Control table: trigger value only during FILL, ignored arm, abort priority, reset
    tv = W'(53'h1234);
    tbl[0]  = '{1'b0, 1'b0, 1'b0, '0, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, '0, 3'd1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, tv, 3'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, tv, 3'd1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, tv, 3'd1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, tv, 3'd2, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, '0, 3'd2, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, '0, 3'd2, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, '0, 3'd2, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, tv, 3'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, '0, 3'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, '0, 3'd1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, '0, 3'd0, 1'b0, 1'b0};
    trig_mask_i = '1;
    trig_value_i = tv;
    for (int i = 0; i < 13; i++) begin
      rst_n_i = tbl[i].rst_n;
      arm_i = tbl[i].arm;
      abort_i = tbl[i].abort;
      debug_i = tbl[i].dbg;
      tick();
      rst_n_i = 1'b1; arm_i = 1'b0; abort_i = 1'b0;
      chk($sformatf("vec%0d state", i), 64'(state_o), 64'(tbl[i].st));
      chk($sformatf("vec%0d trig", i), 64'(triggered_o), 64'(tbl[i].trig));
      chk($sformatf("vec%0d valid", i), 64'(rd_valid_o), 64'(tbl[i].vld));
    end

    // Cycle-count capture with a long ARMED phase (pointer wraps)
    run_capture("t1", 0, '1, W'(100), 0, 0, 0);
    chk("t1 count", 64'(rx_words.size()), 64'(NW));
    if (rx_words.size() == NW) begin
      chk("t1 oldest", 64'(rx_words[0]), 64'd96);
      chk("t1 trigger", 64'(rx_words[16]), 64'd100);
      chk("t1 newest", 64'(rx_words[60]), 64'd111);
      chk("t1 upper", 64'(rx_words[17]), 64'd0);
    end
    ref1 = rx_words;

    // Same capture with 50% backpressure
    run_capture("t4", 0, '1, W'(100), 50, 0, 0);
    chk("t4 count", 64'(rx_words.size()), 64'(ref1.size()));
    for (int i = 0; i < NW; i++)
      if (i < rx_words.size() && i < ref1.size())
        chk($sformatf("t4 seq%0d", i), 64'(rx_words[i]), 64'(ref1[i]));

    // Zero mask: immediate trigger, zero-extended upper bits
    run_capture("t5", 1, '0, '0, 20, 0, 0);
    for (int k = 0; k < D; k++)
      if (4*k + 3 < rx_words.size())
        chk($sformatf("t5 pad%0d", k), 64'(rx_words[4*k+3] >> 5), 64'd0);

    // Random sparse masks, random data, random stalls
    for (int n = 0; n < 3; n++) begin
      m = W'(64'h7 << $urandom_range(50));
      r = {$urandom, $urandom};
      v = r[W-1:0] & m;
      run_capture($sformatf("rnd%0d", n), 1, m, v, 30, 0, 0);
    end

    // Reset, then abort, in mid-readout; then a fresh complete capture
    run_capture("t6r", 0, '1, W'(40), 0, 10, 1);
    run_capture("t6a", 1, '0, '0, 25, 37, 2);
    run_capture("t6f", 0, '1, W'(30), 10, 0, 0);
    chk("t6f count", 64'(rx_words.size()), 64'(NW));
    if (rx_words.size() == NW) chk("t6f trigger", 64'(rx_words[16]), 64'd30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
